// File: rtl/aes_round_sequencer_pkg.sv
// Shared types for the iterative AES round sequencer: FSM states, block/round types,
// and the key-size to round-count mapping.
package AESDefinitions;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    typedef logic [127:0] block_t;
    typedef logic [3:0]   round_idx_t;

    // Zero flags an unsupported key size; the sequencer refuses to elaborate on it.
    function automatic int NumRounds(input int key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            256:     return 14;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES encrypt controller: initial AddRoundKey, then NR passes through the external round datapath.
// Optional AES_SEQ_ABORT_EN adds an abort input that discards the block in flight.
module aes_round_sequencer
    import AESDefinitions::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clock,
    input  logic         reset,
`ifdef AES_SEQ_ABORT_EN
    input  logic         abort,
`endif
    input  logic         key_valid,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic [127:0] rnd_in,
    output logic         rnd_final,
    input  logic [127:0] rnd_out,
    output logic         busy
);

    localparam int         NR_INT = NumRounds(KEY_BITS);
    localparam round_idx_t NR     = round_idx_t'(NR_INT);

    if (NR_INT == 0) begin : g_bad_key_bits
        $error("aes_round_sequencer: KEY_BITS must be 128, 192 or 256");
    end

    seq_state_t st, st_nxt;
    block_t     state_q, state_nxt;
    round_idx_t round_q, round_nxt;
    logic       abort_req;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st      <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            st      <= st_nxt;
            state_q <= state_nxt;
            round_q <= round_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        state_nxt = state_q;
        round_nxt = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        rk_idx    = '0;
        rnd_in    = '0;
        rnd_final = 1'b0;
        busy      = 1'b0;
        case (st)
            IDLE: begin
                // Held low while reset is asserted so in_ready shows its reset value.
                in_ready = key_valid && reset && !abort_req;
                if (in_valid && in_ready) begin
                    state_nxt = in_data ^ rk_data;
                    round_nxt = 4'd1;
                    st_nxt    = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                rk_idx    = round_q;
                rnd_in    = state_q;
                rnd_final = (round_q == NR);
                state_nxt = rnd_out;
                if (round_q == NR) begin
                    round_nxt = '0;
                    st_nxt    = DONE;
                end else begin
                    round_nxt = round_q + 4'd1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = state_q;
                if (out_ready) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
        if (abort_req && st != IDLE) begin
            st_nxt    = IDLE;
            round_nxt = '0;
            state_nxt = '0;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench: two sequencers (AES-128 and AES-256) sharing host inputs, each driving a behavioural
// round datapath and key store; ciphertexts are checked through a per-instance scoreboard.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KEY128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clock = 1'b0;
    logic         reset, key_valid, in_valid, out_ready;
    logic [127:0] in_data;
`ifdef AES_SEQ_ABORT_EN
    logic         abort;
`endif
    logic [1:0]   in_ready, ov, rnd_final, busy;
    logic [127:0] od [2];
    logic [127:0] rk_data [2];
    logic [127:0] rnd_in [2];
    logic [127:0] rnd_out [2];
    logic [3:0]   rk_idx [2];
    logic [127:0] rks [2][16];

    int total = 0, bad = 0, cyc = 0;
    int acc [2];
    logic [1:0] pov;
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] c0, c1, c2, c3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
                b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
                b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
                b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    task automatic expand(input int g, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rks[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic int nr_of(input int g);
        return (g == 0) ? 10 : 14;
    endfunction

    function automatic logic [127:0] encrypt(input int g, input logic [127:0] pt);
        logic [127:0] s = pt ^ rks[g][0];
        for (int r = 1; r <= nr_of(g); r++) s = aes_round(s, rks[g][r], r == nr_of(g));
        return s;
    endfunction

    // ---------------- DUTs + external datapath ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes_round_sequencer #(.KEY_BITS((g == 0) ? 128 : 256)) u_dut (
            .clock     (clock),
            .reset     (reset),
`ifdef AES_SEQ_ABORT_EN
            .abort     (abort),
`endif
            .key_valid (key_valid),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_data  (od[g]),
            .rk_idx    (rk_idx[g]),
            .rk_data   (rk_data[g]),
            .rnd_in    (rnd_in[g]),
            .rnd_final (rnd_final[g]),
            .rnd_out   (rnd_out[g]),
            .busy      (busy[g])
        );
        assign rk_data[g] = rks[g][rk_idx[g]];
        assign rnd_out[g] = aes_round(rnd_in[g], rk_data[g], rnd_final[g]);
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_clear();
        q0.delete();
        q1.delete();
    endtask

    // Scoreboard: push on accept, compare every DONE cycle against the head, pop on consume.
    always @(negedge clock) begin
        if (!reset) begin
            pov = 2'b00;
        end else begin
            for (int g = 0; g < 2; g++) begin
                logic [127:0] e;
                int sz;
                if (in_valid && in_ready[g]) begin
                    e = (in_data == PT) ? ((g == 0) ? CT128 : CT256) : encrypt(g, in_data);
                    if (g == 0) q0.push_back(e); else q1.push_back(e);
                    acc[g] = cyc + 1;
                end
                if (busy[g] && !ov[g]) begin
                    chk($sformatf("rk_idx%0d", g), 128'(rk_idx[g]), 128'(cyc - acc[g] + 1));
                    chk($sformatf("rnd_final%0d", g), 128'(rnd_final[g]), 128'((cyc - acc[g] + 1) == nr_of(g)));
                end else if (!busy[g]) begin
                    chk($sformatf("idle_rk%0d", g), {123'b0, rnd_final[g], rk_idx[g]}, 128'h0);
                end
                if (ov[g] && !pov[g])
                    chk($sformatf("latency%0d", g), 128'(cyc - acc[g]), 128'(nr_of(g)));
                if (ov[g]) begin
                    sz = (g == 0) ? q0.size() : q1.size();
                    if (sz == 0) begin
                        chk($sformatf("unexpected_out%0d", g), 128'(ov[g]), 128'h0);
                    end else begin
                        e = (g == 0) ? q0[0] : q1[0];
                        chk($sformatf("out_data%0d", g), od[g], e);
                        chk($sformatf("in_ready_done%0d", g), 128'(in_ready[g]), 128'h0);
                        if (out_ready) begin
                            if (g == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end
                    end
                end
                pov[g] = ov[g];
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [127:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy != 2'b00) && n < 60) begin
            step();
            n++;
        end
        chk("idle_timeout", 128'(busy), 128'h0);
    endtask

    task automatic wait_round(input int r);
        int n = 0;
        while (!(busy[0] && rk_idx[0] == 4'(r)) && n < 40) begin
            step();
            n++;
        end
        chk("round_timeout", 128'(rk_idx[0]), 128'(r));
    endtask

    task automatic chk_rst();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_ctl%0d", g),
                {122'b0, in_ready[g], ov[g], rnd_final[g], busy[g], rk_idx[g] != 4'd0, 1'b0}, 128'h0);
            chk($sformatf("rst_out_data%0d", g), od[g], 128'h0);
            chk($sformatf("rst_rnd_in%0d", g), rnd_in[g], 128'h0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b0; key_valid = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef AES_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        pov = 2'b00;
        expand(0, {KEY128, 128'h0}, 4);
        expand(1, KEY256, 8);
        repeat (3) step();
        chk_rst();
        reset = 1'b1;
        step();

        // FIPS-197 C.1 / C.3 plus random blocks
        send(PT);
        wait_idle();
        repeat (3) begin
            send(rnd128());
            wait_idle();
        end

        // Backpressure in DONE
        out_ready = 1'b0;
        send(rnd128());
        n = 0;
        while (ov != 2'b11 && n < 40) begin
            step();
            n++;
        end
        chk("done_timeout", 128'(ov), 128'h3);
        in_valid = 1'b1;
        in_data  = rnd128();
        repeat (5) step();
        chk("bp_hold", {126'b0, ov}, 128'h3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", {126'b0, busy | ov}, 128'h0);

        // key_valid gates acceptance
        key_valid = 1'b0;
        in_valid  = 1'b1;
        in_data   = rnd128();
        repeat (3) step();
        chk("kv_low", {126'b0, in_ready | busy}, 128'h0);
        key_valid = 1'b1;
        #1;
        chk("kv_high_ready", 128'(in_ready), 128'h3);
        step();
        in_valid = 1'b0;
        chk("kv_accept", 128'(busy), 128'h3);
        wait_idle();

        // Reset mid-run
        send(rnd128());
        wait_round(5);
        reset = 1'b0;
        #1;
        chk_rst();
        sb_clear();
        step();
        step();
        reset = 1'b1;
        repeat (16) step();
        chk("post_rst_idle", {126'b0, busy | ov}, 128'h0);
        send(PT);
        wait_idle();

`ifdef AES_SEQ_ABORT_EN
        send(rnd128());
        wait_round(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        sb_clear();
        chk("abort_run", {126'b0, busy | ov}, 128'h0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = rnd128();
        #1;
        chk("abort_idle_ready", 128'(in_ready), 128'h0);
        step();
        chk("abort_idle_busy", 128'(busy), 128'h0);
        abort    = 1'b0;
        in_valid = 1'b0;
        send(rnd128());
        wait_idle();
`endif

        step();
        chk("sb_drained", 128'(q0.size() + q1.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
